// File: rtl/bod_pkg.sv
// Shared types and constants for the brownout-detection ADC front end.
// Pure declarations: no latency, no flow control.
// No backpressure: nothing here holds state.
package bod_pkg;

    localparam int ADC_W_DEFAULT = 20;
    localparam int HYST_W        = 12;

    typedef enum logic [2:0] {
        IDLE,
        CONVST,
        WAIT,
        SHIFT,
        UPDATE
    } bod_state_t;

endpackage

// File: rtl/bod_adc_frontend_cmp.sv
// Hysteretic threshold comparator: set below thresh, clear at or above thresh + hyst.
// Flag updates on the clock edge where upd_en is high and holds otherwise.
// No backpressure: evaluated once per update strobe.
module bod_hyst_cmp
    import bod_pkg::*;
#(
    parameter int W = ADC_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd_en,
    input  logic [W-1:0]      sample,
    input  logic [W-1:0]      thresh,
    input  logic [HYST_W-1:0] hyst,
    output logic              flag
);

    // One extra bit so a clear level beyond full scale stays unreachable instead of wrapping.
    logic [W:0] clr_lvl;

    assign clr_lvl = {1'b0, thresh} + {{(W + 1 - HYST_W){1'b0}}, hyst};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag <= 1'b0;
        end else if (upd_en) begin
            if (sample < thresh) begin
                flag <= 1'b1;
            end else if ({1'b0, sample} >= clr_lvl) begin
                flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bod_adc_frontend.sv
// Periodic serial-ADC reader producing adc_in plus warning/critical brownout flags.
// Latency: tick to sample_valid is 2 + CONV_CYCLES + 2*CLK_DIV*ADC_W cycles.
// No backpressure: a period tick arriving while busy is dropped and latched in overrun.
module bod_adc_frontend
    import bod_pkg::*;
#(
    parameter int ADC_W         = ADC_W_DEFAULT,
    parameter int CLK_DIV       = 2,
    parameter int CONV_CYCLES   = 8,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADC_W-1:0]  warn_thresh,
    input  logic [ADC_W-1:0]  crit_thresh,
    input  logic [HYST_W-1:0] hyst,
    input  logic              adc_sdo,
    output logic              adc_convst,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic [ADC_W-1:0]  adc_in,
    output logic              sample_valid,
    output logic              BOD_out1,
    output logic              BOD_out2,
    output logic              busy,
    output logic              overrun
);

    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int WW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (ADC_W > 1) ? $clog2(ADC_W) : 1;

    bod_state_t       state;
    bod_state_t       state_nxt;
    logic [PW-1:0]    period_cnt;
    logic [WW-1:0]    wait_cnt;
    logic [DW-1:0]    div_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [ADC_W-1:0] shreg;
    logic             tick;
    logic             sclk_edge;
    logic             last_bit;
    logic             upd_en;

    assign tick      = (period_cnt == PW'(SAMPLE_PERIOD - 1));
    assign sclk_edge = (div_cnt == DW'(CLK_DIV - 1));
    assign last_bit  = (bit_cnt == BW'(ADC_W - 1));
    assign upd_en    = (state_nxt == UPDATE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = CONVST;
            CONVST:  state_nxt = WAIT;
            WAIT:    if (wait_cnt == WW'(CONV_CYCLES - 1)) state_nxt = SHIFT;
            // The last falling SCLK edge ends the read, so SCLK is already low in UPDATE.
            SHIFT:   if (sclk_edge && adc_sclk && last_bit) state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt <= '0;
            overrun    <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            if (tick) begin
                period_cnt <= '0;
            end else begin
                period_cnt <= period_cnt + 1'b1;
            end
            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Data is captured on the same clk edge that raises SCLK, MSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            adc_sclk <= 1'b0;
            shreg    <= '0;
        end else if (state == SHIFT) begin
            if (sclk_edge) begin
                div_cnt  <= '0;
                adc_sclk <= ~adc_sclk;
                if (!adc_sclk) begin
                    shreg <= {shreg[ADC_W-2:0], adc_sdo};
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end else begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            adc_sclk <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adc_convst   <= 1'b0;
            adc_cs_n     <= 1'b1;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            adc_in       <= '0;
        end else begin
            adc_convst   <= (state_nxt == CONVST);
            adc_cs_n     <= (state_nxt != SHIFT);
            sample_valid <= upd_en;
            busy         <= (state_nxt != IDLE);
            if (upd_en) begin
                adc_in <= shreg;
            end
        end
    end

    bod_hyst_cmp #(.W(ADC_W)) u_warn_cmp (
        .clk    (clk),
        .rst    (rst),
        .upd_en (upd_en),
        .sample (shreg),
        .thresh (warn_thresh),
        .hyst   (hyst),
        .flag   (BOD_out1)
    );

    bod_hyst_cmp #(.W(ADC_W)) u_crit_cmp (
        .clk    (clk),
        .rst    (rst),
        .upd_en (upd_en),
        .sample (shreg),
        .thresh (crit_thresh),
        .hyst   (hyst),
        .flag   (BOD_out2)
    );

endmodule

// File: tb/tb_bod_adc_frontend.sv
// Scoreboard bench: random and directed ADC words, reference flag model, overrun instance.
module tb_bod_adc_frontend;

    localparam int ADC_W = 20;
    localparam int SP    = 200;
    localparam int SP2   = 50;
    localparam int LAT   = 89;   // convst cycle to sample_valid cycle

    typedef struct packed {
        logic [ADC_W-1:0] v;
        logic             f1;
        logic             f2;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [ADC_W-1:0]  warn;
    logic [ADC_W-1:0]  crit;
    logic [11:0]       hyst_v;
    logic              adc_sdo, adc_convst, adc_cs_n, adc_sclk;
    logic [ADC_W-1:0]  adc_in;
    logic              sample_valid, bod1, bod2, busy, overrun;
    logic              adc_sdo2, adc_convst2, adc_cs_n2, adc_sclk2;
    logic [ADC_W-1:0]  adc_in2;
    logic              sample_valid2, bod1_2, bod2_2, busy2, overrun2;

    logic [ADC_W-1:0]  adc_word;
    logic [ADC_W-1:0]  adc_word2 = 20'h5A5A5;
    logic [4:0]        idx, idx2;
    logic              adc_prev_sclk, adc_prev_sclk2;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    rel_cyc  = 0;
    int    rel_id   = 0;
    int    rel_seen = 0;
    int    convst_cyc = 0;
    int    rises    = 0;
    logic  prev_sv, prev_cv, prev_sclk, prev_cs_n;
    logic  m1, m2;

    bod_adc_frontend #(.ADC_W(ADC_W), .CLK_DIV(2), .CONV_CYCLES(8), .SAMPLE_PERIOD(SP)) dut (
        .clk(clk), .rst(rst), .warn_thresh(warn), .crit_thresh(crit), .hyst(hyst_v),
        .adc_sdo(adc_sdo), .adc_convst(adc_convst), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
        .adc_in(adc_in), .sample_valid(sample_valid), .BOD_out1(bod1), .BOD_out2(bod2),
        .busy(busy), .overrun(overrun)
    );

    bod_adc_frontend #(.ADC_W(ADC_W), .CLK_DIV(2), .CONV_CYCLES(8), .SAMPLE_PERIOD(SP2)) dut_ovr (
        .clk(clk), .rst(rst), .warn_thresh(20'h0), .crit_thresh(20'h0), .hyst(12'h0),
        .adc_sdo(adc_sdo2), .adc_convst(adc_convst2), .adc_cs_n(adc_cs_n2), .adc_sclk(adc_sclk2),
        .adc_in(adc_in2), .sample_valid(sample_valid2), .BOD_out1(bod1_2), .BOD_out2(bod2_2),
        .busy(busy2), .overrun(overrun2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ADC models: MSB waits while CS_N is high, next bit after each falling SCLK.
    assign adc_sdo  = adc_word[idx];
    assign adc_sdo2 = adc_word2[idx2];

    always @(negedge clk) begin
        if (adc_cs_n) idx = 5'(ADC_W - 1);
        else if (adc_prev_sclk && !adc_sclk && idx != 5'd0) idx = idx - 5'd1;
        if (adc_cs_n2) idx2 = 5'(ADC_W - 1);
        else if (adc_prev_sclk2 && !adc_sclk2 && idx2 != 5'd0) idx2 = idx2 - 5'd1;
        adc_prev_sclk  = adc_sclk;
        adc_prev_sclk2 = adc_sclk2;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic next_flag(logic cur, int s, int th, int hy);
        if (s < th) return 1'b1;
        if (s >= th + hy) return 1'b0;
        return cur;
    endfunction

    // Monitor: pops the scoreboard on every sample_valid and watches protocol timing.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (adc_convst) begin
                check("convst_width", 32'(prev_cv), 32'd0);
                convst_cyc = cyc;
                if (rel_id != rel_seen) begin
                    rel_seen = rel_id;
                    check("first_tick", 32'(cyc - rel_cyc), 32'(SP));
                end
            end
            if (sample_valid) begin
                check("valid_width", 32'(prev_sv), 32'd0);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got adc_in 0x%0h, expected no sample", adc_in);
                end else begin
                    e = sb.pop_front();
                    check("adc_in", 32'(adc_in), 32'(e.v));
                    check("bod_out1", 32'(bod1), 32'(e.f1));
                    check("bod_out2", 32'(bod2), 32'(e.f2));
                    check("latency", 32'(cyc - convst_cyc), 32'(LAT));
                end
            end
            if (!adc_cs_n && prev_cs_n) rises = 0;
            if (!adc_cs_n && adc_sclk && !prev_sclk) rises++;
            if (adc_cs_n && !prev_cs_n) begin
                check("sclk_rises", 32'(rises), 32'(ADC_W));
                check("sclk_low_at_update", 32'(adc_sclk), 32'd0);
            end
            if (cyc - rel_cyc == 2 * SP2 - 1) check("ovr_before_2nd_tick", 32'(overrun2), 32'd0);
            if (cyc - rel_cyc == 2 * SP2)     check("ovr_at_2nd_tick", 32'(overrun2), 32'd1);
            if (cyc - rel_cyc == SP2 + LAT)   check("ovr_valid_time", 32'(sample_valid2), 32'd1);
            if (sample_valid2) check("ovr_adc_in", 32'(adc_in2), 32'h5A5A5);
        end
        prev_sv   = sample_valid;
        prev_cv   = adc_convst;
        prev_sclk = adc_sclk;
        prev_cs_n = adc_cs_n;
    end

    task automatic reset_checks(input string tag);
        check({tag, "_convst"}, 32'(adc_convst), 32'd0);
        check({tag, "_cs_n"}, 32'(adc_cs_n), 32'd1);
        check({tag, "_sclk"}, 32'(adc_sclk), 32'd0);
        check({tag, "_adc_in"}, 32'(adc_in), 32'd0);
        check({tag, "_valid"}, 32'(sample_valid), 32'd0);
        check({tag, "_bod1"}, 32'(bod1), 32'd0);
        check({tag, "_bod2"}, 32'(bod2), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_ovr2"}, 32'(overrun2), 32'd0);
        check({tag, "_cs_n2"}, 32'(adc_cs_n2), 32'd1);
    endtask

    task automatic wait_convst(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * SP; i++) begin
            @(negedge clk);
            if (adc_convst) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("convst_timeout", 32'(adc_convst), 32'd1);
    endtask

    // Thresholds and the ADC word are applied right after convst, well before the update.
    task automatic do_sample(input int s, input int w, input int c, input int h);
        bit   ok;
        exp_t e;
        wait_convst(ok);
        if (ok) begin
            adc_word = 20'(s);
            warn     = 20'(w);
            crit     = 20'(c);
            hyst_v   = 12'(h);
            m1 = next_flag(m1, s, w, h);
            m2 = next_flag(m2, s, c, h);
            e.v  = 20'(s);
            e.f1 = m1;
            e.f2 = m2;
            sb.push_back(e);
        end
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst     = 1'b0;
        rel_cyc = cyc;
        rel_id++;
    endtask

    initial begin
        bit ok;
        int n, w, c, h, s;
        rst = 1'b1;
        warn = 20'h80000;
        crit = 20'h40000;
        hyst_v = 12'h100;
        adc_word = '0;
        m1 = 1'b0;
        m2 = 1'b0;
        repeat (4) @(negedge clk);
        reset_checks("rst");
        release_rst();

        do_sample('hABCDE, 'h80000, 'h40000, 'h100);
        do_sample('h7FFFF, 'h80000, 'h40000, 'h100);
        do_sample('h80050, 'h80000, 'h40000, 'h100);
        do_sample('h80100, 'h80000, 'h40000, 'h100);
        do_sample('h3FFFF, 'h80000, 'h40000, 'h100);
        do_sample('h40100, 'h80000, 'h40000, 'h100);
        check("ovr_sticky", 32'(overrun2), 32'd1);

        // Abort a read after 7 SCLK rising edges.
        wait_convst(ok);
        adc_word = 20'h13579;
        n = 0;
        for (int i = 0; i < 4 * SP && n < 7; i++) begin
            @(negedge clk);
            if (!adc_cs_n && adc_sclk && !prev_sclk) n++;
        end
        check("mid_shift_edges", 32'(n), 32'd7);
        rst = 1'b1;
        #1;
        reset_checks("mid_rst");
        m1 = 1'b0;
        m2 = 1'b0;
        repeat (3) @(negedge clk);
        release_rst();

        do_sample('h12345, 'h80000, 'h40000, 'h100);
        do_sample('hFFFFE, 'hFFFFF, 'h00000, 'hFFF);
        do_sample('hFFFFF, 'hFFFFF, 'h00000, 'hFFF);
        do_sample('hFFFFF, 'hFFFFF, 'h00000, 'hFFF);

        for (int i = 0; i < 8; i++) begin
            w = int'($urandom_range(0, 'hFFFFF));
            c = int'($urandom_range(0, 'hFFFFF));
            h = int'($urandom_range(0, 'hFFF));
            s = ((i % 2) != 0 ? w : c) + int'($urandom_range(0, 2 * h + 2)) - h - 1;
            if (i % 4 == 3) s = int'($urandom_range(0, 'hFFFFF));
            if (s < 0) s = 0;
            if (s > 'hFFFFF) s = 'hFFFFF;
            do_sample(s, w, c, h);
        end

        for (int i = 0; i < 3 * SP && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("no_overrun_main", 32'(overrun), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
